// File: rtl/linebuffer_scanout.sv
// Scanout side of the sprite line buffers: reads the displayed buffer, clears each location
// behind the read, and owns the per-line draw/display swap.
module linebuffer_scanout #(
   parameter int unsigned WIDTH   = 256,
   parameter int unsigned X_START = 0,
   parameter int unsigned AW      = 9
) (
   input  logic          clk_i,
   input  logic          rst_ni,
   input  logic          pix_ce_i,
   input  logic          line_start_i,
   input  logic [11:0]   rd_data_a_i,
   input  logic [11:0]   rd_data_b_i,
   output logic [AW-1:0] addr_o,
   output logic          clr_we_a_o,
   output logic          clr_we_b_o,
   output logic          draw_sel_o,
   output logic [11:0]   pix_out_o,
   output logic          pix_opaque_o,
   output logic          line_active_o
);

   localparam int unsigned CW = $clog2(WIDTH + 1);
   localparam logic [AW-1:0] XStartA = AW'(X_START);
   localparam logic [CW-1:0] WidthC  = CW'(WIDTH);

   typedef enum logic [1:0] {StIdle, StRd, StClr} state_e;

   state_e        state_q, state_d;
   logic [AW-1:0] x_q, x_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          draw_sel_q, draw_sel_d;
   logic [11:0]   pix_q, pix_d;
   logic          opaque_q, opaque_d;
   logic          active_q, active_d;
   logic [11:0]   rd_data;
   logic [CW-1:0] cnt_inc;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= StIdle;
         x_q        <= XStartA;
         cnt_q      <= '0;
         draw_sel_q <= 1'b0;
         pix_q      <= '0;
         opaque_q   <= 1'b0;
         active_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         x_q        <= x_d;
         cnt_q      <= cnt_d;
         draw_sel_q <= draw_sel_d;
         pix_q      <= pix_d;
         opaque_q   <= opaque_d;
         active_q   <= active_d;
      end
   end

   // The displayed buffer is always the one the renderer does not own.
   assign rd_data = draw_sel_q ? rd_data_a_i : rd_data_b_i;
   assign cnt_inc = cnt_q + 1'b1;

   always_comb begin
      state_d    = state_q;
      x_d        = x_q;
      cnt_d      = cnt_q;
      draw_sel_d = draw_sel_q;
      pix_d      = pix_q;
      opaque_d   = opaque_q;
      active_d   = active_q;

      case (state_q)
         StIdle: begin
            pix_d    = '0;
            opaque_d = 1'b0;
         end
         StRd: begin
            if (pix_ce_i) state_d = StClr;
         end
         StClr: begin
            pix_d    = rd_data;
            opaque_d = |rd_data[3:0];
            x_d      = x_q + 1'b1;
            cnt_d    = cnt_inc;
            if (cnt_inc == WidthC) begin
               state_d  = StIdle;
               active_d = 1'b0;
            end else begin
               state_d = StRd;
            end
         end
         default: state_d = StIdle;
      endcase

      // Line start overrides everything; an in-flight clear still lands on the old buffer.
      if (line_start_i) begin
         draw_sel_d = ~draw_sel_q;
         x_d        = XStartA;
         cnt_d      = '0;
         state_d    = StRd;
         active_d   = 1'b1;
      end
   end

   assign addr_o        = x_q;
   assign clr_we_a_o    = (state_q == StClr) &&  draw_sel_q;
   assign clr_we_b_o    = (state_q == StClr) && !draw_sel_q;
   assign draw_sel_o    = draw_sel_q;
   assign pix_out_o     = pix_q;
   assign pix_opaque_o  = opaque_q;
   assign line_active_o = active_q;

endmodule

// File: tb/tb_linebuffer_scanout.sv
// Bench for linebuffer_scanout: directed cycle table plus randomized full lines checked
// against a snapshot model of the displayed buffer.
module tb_linebuffer_scanout;

   localparam int unsigned AW = 9;
   localparam int unsigned W  = 256;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          pix_ce, line_start;
   logic [11:0]   rd_a, rd_b;
   logic [AW-1:0] addr;
   logic          clr_a, clr_b, dsel, opq, act;
   logic [11:0]   pix;

   logic [11:0] mem_a [512];
   logic [11:0] mem_b [512];

   int n_vec = 0;
   int n_err = 0;
   int n_stb_a = 0;
   int n_stb_b = 0;
   logic m_dsel;

   linebuffer_scanout #(.WIDTH(W), .X_START(0), .AW(AW)) dut (
      .clk_i        (clk),
      .rst_ni       (rst_n),
      .pix_ce_i     (pix_ce),
      .line_start_i (line_start),
      .rd_data_a_i  (rd_a),
      .rd_data_b_i  (rd_b),
      .addr_o       (addr),
      .clr_we_a_o   (clr_a),
      .clr_we_b_o   (clr_b),
      .draw_sel_o   (dsel),
      .pix_out_o    (pix),
      .pix_opaque_o (opq),
      .line_active_o(act)
   );

   always #5 clk = ~clk;

   // Pixel RAM models: registered read, zero written on clear strobe.
   always @(posedge clk) begin
      rd_a <= mem_a[addr];
      rd_b <= mem_b[addr];
      if (clr_a) mem_a[addr] <= '0;
      if (clr_b) mem_b[addr] <= '0;
   end

   task automatic check(input string name, input logic [31:0] actual, input logic [31:0] exp);
      n_vec++;
      if (actual !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, actual, exp, $time);
      end
   endtask

   // Any clear strobe must target only the buffer opposite DRAW_SEL.
   always @(negedge clk) begin
      if (rst_n && (clr_a || clr_b)) begin
         check("strobe_target", {30'd0, clr_a, clr_b}, dsel ? 32'd2 : 32'd1);
         if (clr_a) n_stb_a++;
         if (clr_b) n_stb_b++;
      end
   end

   task automatic step(input logic ls, input logic ce);
      line_start = ls;
      pix_ce     = ce;
      @(posedge clk);
      #1;
      line_start = 1'b0;
      pix_ce     = 1'b0;
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_dsel"}, {31'd0, dsel}, 32'd0);
      check({tag, "_strobes"}, {30'd0, clr_a, clr_b}, 32'd0);
      check({tag, "_pix"}, {20'd0, pix}, 32'd0);
      check({tag, "_opq"}, {31'd0, opq}, 32'd0);
      check({tag, "_act"}, {31'd0, act}, 32'd0);
      check({tag, "_addr"}, {23'd0, addr}, 32'd0);
   endtask

   // Full line against a snapshot of the displayed buffer taken at LINE_START.
   task automatic run_line(input int gapmax);
      logic [11:0] exp_pix [W];
      int sa, sb, nz, chg;
      logic [11:0] hi_snap [256];
      step(1'b1, 1'b0);
      m_dsel = ~m_dsel;
      check("line_dsel", {31'd0, dsel}, {31'd0, m_dsel});
      check("line_act", {31'd0, act}, 32'd1);
      for (int i = 0; i < W; i++) exp_pix[i] = m_dsel ? mem_a[i] : mem_b[i];
      for (int i = 0; i < 256; i++) hi_snap[i] = m_dsel ? mem_a[256 + i] : mem_b[256 + i];
      sa = n_stb_a;
      sb = n_stb_b;
      for (int k = 0; k < W; k++) begin
         step(1'b0, 1'b1);
         check("clr_addr", {23'd0, addr}, k);
         check("clr_we", {30'd0, clr_a, clr_b}, m_dsel ? 32'd2 : 32'd1);
         step(1'b0, 1'b0);
         check("pix", {20'd0, pix}, {20'd0, exp_pix[k]});
         check("opq", {31'd0, opq}, {31'd0, |exp_pix[k][3:0]});
         check("act_in_line", {31'd0, act}, (k != W - 1) ? 32'd1 : 32'd0);
         if (k != W - 1) begin
            repeat ($urandom_range(0, gapmax)) begin
               step(1'b0, 1'b0);
               check("pix_hold", {20'd0, pix}, {20'd0, exp_pix[k]});
            end
         end
      end
      repeat (3) step(1'b0, 1'b1);
      check("idle_pix", {20'd0, pix}, 32'd0);
      check("idle_opq", {31'd0, opq}, 32'd0);
      check("idle_act", {31'd0, act}, 32'd0);
      check("stb_count_disp", m_dsel ? n_stb_a - sa : n_stb_b - sb, W);
      check("stb_count_draw", m_dsel ? n_stb_b - sb : n_stb_a - sa, 32'd0);
      nz  = 0;
      chg = 0;
      for (int i = 0; i < W; i++) if ((m_dsel ? mem_a[i] : mem_b[i]) != 12'h0) nz++;
      for (int i = 0; i < 256; i++)
         if ((m_dsel ? mem_a[256 + i] : mem_b[256 + i]) != hi_snap[i]) chg++;
      check("readback_zero", nz, 32'd0);
      check("upper_untouched", chg, 32'd0);
   endtask

   task automatic fill_random();
      logic [11:0] v;
      for (int i = 0; i < 512; i++) begin
         v = 12'($urandom);
         if ($urandom_range(0, 1) == 1) v[3:0] = 4'h0;
         mem_a[i] <= v;
         v = 12'($urandom);
         if ($urandom_range(0, 1) == 1) v[3:0] = 4'h0;
         mem_b[i] <= v;
      end
   endtask

   typedef struct {
      logic        ls;
      logic        ce;
      logic        chk_pix;
      logic [11:0] pix;
      logic        opq;
      logic [8:0]  addr;
      logic        cla;
      logic        clb;
      logic        dsel;
      logic        act;
   } vec_t;

   vec_t tbl [14];

   initial begin
      int nz;
      rst_n      = 1'b0;
      pix_ce     = 1'b0;
      line_start = 1'b0;
      m_dsel     = 1'b0;
      for (int i = 0; i < 512; i++) begin
         mem_a[i] <= '0;
         mem_b[i] <= '0;
      end
      #1;
      check_reset_vals("in_reset");
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (3) step(1'b0, 1'b1);
      check_reset_vals("post_reset");

      // Directed cycle table: short line on A, ignored PIX_CE in CLR, LINE_START during CLR.
      //             ls    ce   chk  pix      opq   addr  cla   clb   dsel  act
      tbl[0]  = '{1'b1, 1'b0, 1'b1, 12'h000, 1'b0, 9'd0, 1'b0, 1'b0, 1'b1, 1'b1};
      tbl[1]  = '{1'b0, 1'b1, 1'b1, 12'h000, 1'b0, 9'd0, 1'b1, 1'b0, 1'b1, 1'b1};
      tbl[2]  = '{1'b0, 1'b0, 1'b1, 12'h3A5, 1'b1, 9'd1, 1'b0, 1'b0, 1'b1, 1'b1};
      tbl[3]  = '{1'b0, 1'b1, 1'b1, 12'h3A5, 1'b1, 9'd1, 1'b1, 1'b0, 1'b1, 1'b1};
      tbl[4]  = '{1'b0, 1'b0, 1'b1, 12'h120, 1'b0, 9'd2, 1'b0, 1'b0, 1'b1, 1'b1};
      tbl[5]  = '{1'b0, 1'b1, 1'b1, 12'h120, 1'b0, 9'd2, 1'b1, 1'b0, 1'b1, 1'b1};
      tbl[6]  = '{1'b0, 1'b0, 1'b1, 12'h00F, 1'b1, 9'd3, 1'b0, 1'b0, 1'b1, 1'b1};
      tbl[7]  = '{1'b0, 1'b1, 1'b1, 12'h00F, 1'b1, 9'd3, 1'b1, 1'b0, 1'b1, 1'b1};
      tbl[8]  = '{1'b0, 1'b1, 1'b1, 12'h000, 1'b0, 9'd4, 1'b0, 1'b0, 1'b1, 1'b1};
      tbl[9]  = '{1'b0, 1'b0, 1'b1, 12'h000, 1'b0, 9'd4, 1'b0, 1'b0, 1'b1, 1'b1};
      tbl[10] = '{1'b0, 1'b1, 1'b1, 12'h000, 1'b0, 9'd4, 1'b1, 1'b0, 1'b1, 1'b1};
      tbl[11] = '{1'b1, 1'b0, 1'b0, 12'h000, 1'b0, 9'd0, 1'b0, 1'b0, 1'b0, 1'b1};
      tbl[12] = '{1'b0, 1'b1, 1'b0, 12'h000, 1'b0, 9'd0, 1'b0, 1'b1, 1'b0, 1'b1};
      tbl[13] = '{1'b0, 1'b0, 1'b1, 12'h456, 1'b1, 9'd1, 1'b0, 1'b0, 1'b0, 1'b1};

      mem_a[0] <= 12'h3A5;
      mem_a[1] <= 12'h120;
      mem_a[2] <= 12'h00F;
      mem_a[3] <= 12'h000;
      mem_a[4] <= 12'h7C1;
      mem_a[5] <= 12'h0AB;
      mem_b[0] <= 12'h456;
      mem_b[1] <= 12'h999;
      for (int r = 0; r < 14; r++) begin
         step(tbl[r].ls, tbl[r].ce);
         if (tbl[r].ls) m_dsel = ~m_dsel;
         if (tbl[r].chk_pix) begin
            check($sformatf("tbl%0d_pix", r), {20'd0, pix}, {20'd0, tbl[r].pix});
            check($sformatf("tbl%0d_opq", r), {31'd0, opq}, {31'd0, tbl[r].opq});
         end
         check($sformatf("tbl%0d_addr", r), {23'd0, addr}, {23'd0, tbl[r].addr});
         check($sformatf("tbl%0d_we", r), {30'd0, clr_a, clr_b}, {30'd0, tbl[r].cla, tbl[r].clb});
         check($sformatf("tbl%0d_dsel", r), {31'd0, dsel}, {31'd0, tbl[r].dsel});
         check($sformatf("tbl%0d_act", r), {31'd0, act}, {31'd0, tbl[r].act});
      end
      nz = 0;
      for (int i = 0; i < 5; i++) if (mem_a[i] != 12'h0) nz++;
      check("tbl_cleared_a", nz, 32'd0);
      check("tbl_aborted_kept", {20'd0, mem_a[5]}, 32'h0AB);
      check("tbl_cleared_b", {20'd0, mem_b[0]}, 32'd0);

      // Randomized full lines, relaxed and back-to-back PIX_CE spacing.
      fill_random();
      run_line(3);
      fill_random();
      run_line(0);

      // Two LINE_STARTs 300 clk apart with no pixels in between.
      step(1'b1, 1'b0);
      m_dsel = ~m_dsel;
      check("ls_a_dsel", {31'd0, dsel}, {31'd0, m_dsel});
      repeat (299) step(1'b0, 1'b0);
      check("ls_gap_act", {31'd0, act}, 32'd1);
      step(1'b1, 1'b0);
      m_dsel = ~m_dsel;
      check("ls_b_dsel", {31'd0, dsel}, {31'd0, m_dsel});

      // Reset during the clear cycle of pixel 50.
      fill_random();
      step(1'b1, 1'b0);
      m_dsel = ~m_dsel;
      repeat (50) begin
         step(1'b0, 1'b1);
         step(1'b0, 1'b0);
      end
      step(1'b0, 1'b1);
      check("pre_rst_we", {30'd0, clr_a, clr_b}, m_dsel ? 32'd2 : 32'd1);
      check("pre_rst_addr", {23'd0, addr}, 32'd50);
      #2 rst_n = 1'b0;
      #1;
      check_reset_vals("async_rst");
      m_dsel = 1'b0;
      @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (4) step(1'b0, 1'b1);
      check_reset_vals("rst_idle");
      step(1'b1, 1'b0);
      m_dsel = ~m_dsel;
      check("rst_ls_dsel", {31'd0, dsel}, {31'd0, m_dsel});
      check("rst_ls_act", {31'd0, act}, 32'd1);
      step(1'b0, 1'b1);
      check("rst_ls_addr", {23'd0, addr}, 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/linebuffer_scanout.md
Name: linebuffer_scanout

Overview:
- Display-side end of the sprite line buffers: reads the buffer pair not being drawn and delivers 12-bit sprite pixels ({palette[7:0], colour[3:0]}) to the mixer.
- Clears each location after reading it, so the buffer is blank when the renderer next writes it.
- Owns the per-line buffer swap; DRAW_SEL tells the write side which buffer it owns.
- Sits between the pixel_ram instances and the priority/colour mixer.

Parameters:
- WIDTH, 256, pixels read per line
- X_START, 0, first buffer address read after LINE_START
- AW, 9, buffer address width

Ports:
- clk  in  1  system clock
- nRESET  in  1  asynchronous active-low reset
- PIX_CE  in  1  pixel clock enable; pulses at least 2 clk apart
- LINE_START  in  1  one-clk pulse at start of each display line
- RD_DATA_A  in  12  registered read data, buffer A (1 clk latency)
- RD_DATA_B  in  12  registered read data, buffer B (1 clk latency)
- ADDR  out  AW  read/clear address to the displayed buffer
- CLR_WE_A  out  1  clear write strobe, buffer A (write data is 0)
- CLR_WE_B  out  1  clear write strobe, buffer B (write data is 0)
- DRAW_SEL  out  1  0: renderer writes A, scanout reads B; 1: the reverse
- PIX_OUT  out  12  sprite pixel {pal, colour}
- PIX_OPAQUE  out  1  1 when PIX_OUT colour nibble is non-zero
- LINE_ACTIVE  out  1  high while pixels of the current line are being read

Behaviour:
- Reset (async, nRESET=0):
  - State IDLE, x=X_START, DRAW_SEL=0.
  - PIX_OUT=0, PIX_OPAQUE=0, LINE_ACTIVE=0, CLR_WE_A/B=0, ADDR=X_START.
- States: IDLE, RD, CLR.
- LINE_START, sampled in any state:
  - Toggles DRAW_SEL.
  - Sets x=X_START and pixel count=0.
  - Enters RD-wait with LINE_ACTIVE=1.
  - Has priority over PIX_CE on the same clk.
- RD: on PIX_CE, ADDR=x is presented to the displayed buffer (the one not selected by DRAW_SEL); go to CLR next clk.
- CLR (exactly one clk):
  - RD_DATA of the displayed buffer is valid and is registered into PIX_OUT.
  - PIX_OPAQUE = |data[3:0].
  - CLR_WE of the displayed buffer is asserted at the same ADDR, writing 0.
  - Then x increments (wraps mod 2^AW) and count increments.
  - If count reaches WIDTH: go to IDLE, LINE_ACTIVE=0. Otherwise wait in RD for the next PIX_CE.
- Latency: PIX_OUT and PIX_OPAQUE are valid 2 clk after the PIX_CE that addressed the pixel, and hold until the next update.
- CLR_WE_A and CLR_WE_B are never high together. The strobe for the DRAW_SEL buffer is never asserted.
- LINE_START during CLR:
  - The clear write completes that clk to the old displayed buffer.
  - The swap takes effect next clk.
  - The aborted line's remaining pixels are not cleared.
- In IDLE:
  - PIX_OUT=0, PIX_OPAQUE=0 from the clk after entering IDLE.
  - PIX_CE is ignored.
- PIX_CE arriving in CLR (spacing violation) is ignored; no pixel is skipped-read twice.
- Reset mid-line: outputs return to reset values immediately. Any in-progress clear is abandoned.

Test Plan:
1. Reset release, no stimulus -> DRAW_SEL=0, all strobes 0, PIX_OUT=0x000, LINE_ACTIVE=0.
2. LINE_START, then PIX_CE every 2 clk, B model preloaded with addr0=0x3A5, addr1=0x120 -> DRAW_SEL=1 (scanout reads A). Repeat with the model on A -> PIX_OUT=0x3A5/OPAQUE=1, then 0x120/OPAQUE=0. CLR_WE on the read buffer at addr 0 and 1. Other strobe stays 0.
3. Full line, WIDTH=256 -> exactly 256 clear strobes at addresses 0..255, then LINE_ACTIVE=0 and PIX_OUT=0. A subsequent readback shows all 256 words are 0.
4. Two consecutive LINE_STARTs 300 clk apart -> DRAW_SEL toggles 0→1→0. Each clear strobe targets the buffer opposite DRAW_SEL.
5. LINE_START coincident with CLR of pixel 10 -> clear at addr 10 on the old buffer, swap next clk, next read at X_START on the new buffer.
6. nRESET asserted mid-line at pixel 50 -> outputs and strobes drop to 0 asynchronously. After release the block waits in IDLE until LINE_START.
